tonemeter: RTL

Frequency-measurement peripheral that is the receiving counterpart of the tone generator. It samples a square-wave conduit input (e.g. a speaker line or an external tone source). It counts rising edges over a fixed one-second gate of `fclk` clock cycles and presents the count, in Hz, to the Nios/Avalon fabric through a small Avalon-MM slave with read latency 1. Software enables the block, polls a status word, and reads the frequency.

---
 rtl/tonemeter_if.sv | 27 ++
 rtl/tonemeter.sv | 117 +++++++++++
 2 files changed

// File: rtl/tonemeter_if.sv
// Avalon-MM register bus between the fabric (master) and the tonemeter (slave).
// Carries address/read/write strobes, write data and registered read data.
// No waitrequest: every strobe completes in the cycle it is presented.
`timescale 1ns/1ps
interface tonemeter_if;
    logic        avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/tonemeter.sv
// Tone frequency meter: counts rising edges of coe_tone over an fclk-cycle gate, reports Hz.
// Latency: edge counted 3 clk edges after first sample; read data registered, latency 1.
// Backpressure: none; the slave accepts one read/write per strobe cycle, no waitrequest.
`timescale 1ns/1ps
module tonemeter #(
    parameter int unsigned fclk = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    tonemeter_if.slave avs,
    input  logic       coe_tone
);
    localparam logic [31:0] LP_GATE_LAST = 32'(fclk - 1);

    logic        r_s1, r_s2, r_s3;
    logic        r_enable;
    logic [31:0] r_gate_cnt;
    logic [31:0] r_edge_cnt;
    logic [31:0] r_freq;
    logic        r_valid;
    logic        r_overrun;
    logic [31:0] r_readdata;

    logic        w_edge;
    logic        w_wr_ctrl;
    logic        w_rd_freq;
    logic        w_rd_stat;
    logic        w_gate_end;
    logic [31:0] w_edge_sum;
    logic [31:0] w_status;
    logic        w_unused_wdata;

    assign w_edge     = r_s2 & ~r_s3;
    assign w_wr_ctrl  = avs.avs_write &  avs.avs_address;
    assign w_rd_freq  = avs.avs_read  & ~avs.avs_address;
    assign w_rd_stat  = avs.avs_read  &  avs.avs_address;
    assign w_gate_end = r_enable & (r_gate_cnt == LP_GATE_LAST);
    // Saturating add; the same sum feeds both the running count and the gate-end latch,
    // so an edge arriving on the gate-end cycle lands in the closing window.
    assign w_edge_sum = (r_edge_cnt == 32'hFFFF_FFFF) ? r_edge_cnt
                                                      : r_edge_cnt + {31'b0, w_edge};
    assign w_status   = {29'b0, r_enable, r_overrun, r_valid};
    assign w_unused_wdata = ^avs.avs_writedata[31:1];

    assign avs.avs_readdata = r_readdata;

    // Two-flop synchronizer plus history flop for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= coe_tone;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Enable bit, written through the CTRL register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enable <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_enable <= avs.avs_writedata[0];
        end
    end

    // Gate and edge counters; a CTRL write, disable or gate end restarts the window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gate_cnt <= 32'd0;
            r_edge_cnt <= 32'd0;
        end else if (w_wr_ctrl || !r_enable || w_gate_end) begin
            r_gate_cnt <= 32'd0;
            r_edge_cnt <= 32'd0;
        end else begin
            r_gate_cnt <= r_gate_cnt + 32'd1;
            r_edge_cnt <= w_edge_sum;
        end
    end

    // Result latch and status flags; a gate-end set beats a same-cycle read clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_freq    <= 32'd0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_gate_end) begin
                r_freq <= w_edge_sum;
            end

            if (w_gate_end) begin
                r_valid <= 1'b1;
            end else if (w_rd_freq) begin
                r_valid <= 1'b0;
            end

            // A FREQ read in the gate-end cycle consumes the old result, so it is no overrun.
            if (w_gate_end && r_valid && !w_rd_freq) begin
                r_overrun <= 1'b1;
            end else if (w_rd_stat) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Registered read data sampled from the read cycle's (pre-update) register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= 32'd0;
        end else if (avs.avs_read) begin
            r_readdata <= avs.avs_address ? w_status : r_freq;
        end
    end
endmodule
